// File: rtl/jtframe_romserve.sv
// Round-robin ROM read server. It grants one client at a time, issues a single
// SDRAM read, joins two 16-bit beats into a 32-bit word and strobes slot_ok.
module jtframe_romserve #(
  parameter int SLOTS = 4,
  parameter int AW    = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [SLOTS-1:0]  slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]  slot_ok,
  output logic [31:0]       slot_din,
  output logic              busy,
  output logic              sdram_req,
  output logic [AW-1:0]     sdram_addr,
  input  logic              sdram_ack,
  input  logic              sdram_rdy,
  input  logic [15:0]       sdram_data
);

  localparam int IW = $clog2(SLOTS);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state_q;
  logic [IW-1:0]    cur_q;
  logic [IW-1:0]    last_q;
  logic             beat_q;
  logic [15:0]      lo_q;
  logic [SLOTS-1:0] slot_ok_q;
  logic [31:0]      slot_din_q;
  logic             busy_q;
  logic             sdram_req_q;
  logic [AW-1:0]    sdram_addr_q;

  logic             gnt_found;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    cand_idx;
  logic [AW-1:0]    gnt_addr;
  logic             take_lo;
  logic             take_hi;
  int unsigned      cand;

  // Search starts just after the last served slot so every client gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= SLOTS; i++) begin
      cand     = (int'(last_q) + i) % SLOTS;
      cand_idx = IW'(cand);
      if (!gnt_found && slot_req[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_addr = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (gnt_idx == IW'(k)) gnt_addr = slot_addr[k*AW +: AW];
    end
  end

  // A beat in the ack cycle is accepted as the first beat.
  always_comb begin
    take_lo = 1'b0;
    take_hi = 1'b0;
    if (sdram_rdy) begin
      if (state_q == REQ && sdram_ack) take_lo = 1'b1;
      if (state_q == WAIT) begin
        take_lo = !beat_q;
        take_hi = beat_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take_lo) lo_q <= sdram_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      last_q       <= IW'(SLOTS - 1);
      beat_q       <= 1'b0;
      slot_ok_q    <= '0;
      slot_din_q   <= '0;
      busy_q       <= 1'b0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      slot_ok_q <= '0;
      case (state_q)
        IDLE: begin
          beat_q <= 1'b0;
          if (!downloading && gnt_found) begin
            cur_q        <= gnt_idx;
            sdram_addr_q <= gnt_addr;
            sdram_req_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req_q <= 1'b0;
            beat_q      <= take_lo;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (take_lo) beat_q <= 1'b1;
          if (take_hi) begin
            slot_din_q <= {sdram_data, lo_q};
            slot_ok_q  <= SLOTS'(1) << cur_q;
            beat_q     <= 1'b0;
            state_q    <= DONE;
          end
        end
        DONE: begin
          // No grant here: the served client gets one edge to drop its request.
          last_q  <= cur_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slot_ok    = slot_ok_q;
  assign slot_din   = slot_din_q;
  assign busy       = busy_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtframe_romserve.sv
// Directed bench for jtframe_romserve: inputs change 1ns after each rising edge,
// outputs are checked at that same point, so each step covers one clock cycle.
module tb_jtframe_romserve;
  localparam int SLOTS = 4;
  localparam int AW    = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic              downloading;
  logic [SLOTS-1:0]  slot_req;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]  slot_ok;
  logic [31:0]       slot_din;
  logic              busy;
  logic              sdram_req;
  logic [AW-1:0]     sdram_addr;
  logic              sdram_ack;
  logic              sdram_rdy;
  logic [15:0]       sdram_data;

  int checks = 0;
  int errors = 0;
  int ok_count = 0;
  int ok_before;
  int n;

  always #5 clk = ~clk;

  jtframe_romserve #(.SLOTS(SLOTS), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .downloading(downloading),
    .slot_req   (slot_req),
    .slot_addr  (slot_addr),
    .slot_ok    (slot_ok),
    .slot_din   (slot_din),
    .busy       (busy),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .sdram_data (sdram_data)
  );

  always @(negedge clk) if (|slot_ok) ok_count++;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    n = 0;
    while (sdram_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk(tag, {31'd0, sdram_req}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; downloading = 1'b0; slot_req = '0; slot_addr = '0;
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_data = '0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, sdram_req}, 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_ok", 32'(slot_ok), 32'd0);
    chk("rst_din", slot_din, 32'd0);
    rst = 1'b0;

    // Single request, minimum latency
    slot_req = 4'b0010; slot_addr[1*AW +: AW] = 22'h00123;
    step();
    chk("t1_req", {31'd0, sdram_req}, 32'd1);
    chk("t1_addr", 32'(sdram_addr), 32'h00123);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_data = 16'hBEEF;
    step();
    chk("t1_reqdrop", {31'd0, sdram_req}, 32'd0);
    sdram_ack = 1'b0; sdram_data = 16'hDEAD; slot_req = '0;
    step();
    chk("t1_ok", 32'(slot_ok), 32'h2);
    chk("t1_din", slot_din, 32'hDEADBEEF);
    chk("t1_busy_done", {31'd0, busy}, 32'd1);
    sdram_rdy = 1'b0;
    step();
    chk("t1_ok_clr", 32'(slot_ok), 32'h0);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_din_hold", slot_din, 32'hDEADBEEF);

    // Simultaneous requests from reset
    do_reset();
    slot_req = 4'b0101; slot_addr[0*AW +: AW] = 22'h00100; slot_addr[2*AW +: AW] = 22'h00200;
    step();
    chk("t2_addr0", 32'(sdram_addr), 32'h00100);
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_data = 16'h1111;
    step();
    sdram_ack = 1'b0; sdram_data = 16'h2222;
    step();
    chk("t2_ok0", 32'(slot_ok), 32'h1);
    chk("t2_din0", slot_din, 32'h22221111);
    sdram_rdy = 1'b0; slot_req = 4'b0100;
    step();
    chk("t2_gap", {31'd0, sdram_req}, 32'd0);
    step();
    chk("t2_req2", {31'd0, sdram_req}, 32'd1);
    chk("t2_addr2", 32'(sdram_addr), 32'h00200);
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_data = 16'h3333;
    step();
    sdram_ack = 1'b0; sdram_data = 16'h4444;
    step();
    chk("t2_ok2", 32'(slot_ok), 32'h4);
    chk("t2_din2", slot_din, 32'h44443333);
    sdram_rdy = 1'b0; slot_req = '0;
    step();

    // Fairness with every slot requesting
    do_reset();
    for (int k = 0; k < SLOTS; k++) slot_addr[k*AW +: AW] = 22'(32'h10 + k);
    slot_req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_req("t3_reqwait");
      chk("t3_addr", 32'(sdram_addr), 32'h10 + (i % 4));
      sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_data = 16'(i);
      step();
      sdram_ack = 1'b0; sdram_data = 16'hA000;
      step();
      chk("t3_order", 32'(slot_ok), 32'(1) << (i % 4));
      chk("t3_din", slot_din, {16'hA000, 16'(i)});
      sdram_rdy = 1'b0;
    end
    slot_req = '0;
    step();

    // Slow controller, stray beat before ack, gapped beats
    ok_before = ok_count;
    slot_req = 4'b0100; slot_addr[2*AW +: AW] = 22'h3ABCD;
    step();
    chk("t4_req", {31'd0, sdram_req}, 32'd1);
    chk("t4_addr", 32'(sdram_addr), 32'h3ABCD);
    slot_addr[2*AW +: AW] = 22'h00077;
    for (int i = 0; i < 4; i++) begin
      sdram_rdy = (i == 1); sdram_data = 16'hBAD0;
      step();
      chk("t4_hold_req", {31'd0, sdram_req}, 32'd1);
      chk("t4_hold_addr", 32'(sdram_addr), 32'h3ABCD);
    end
    sdram_ack = 1'b1; sdram_rdy = 1'b0;
    step();
    chk("t4_req_off", {31'd0, sdram_req}, 32'd0);
    sdram_ack = 1'b0; sdram_rdy = 1'b1; sdram_data = 16'h5678;
    step();
    sdram_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_gap_ok", 32'(slot_ok), 32'h0);
    end
    sdram_rdy = 1'b1; sdram_data = 16'h1234;
    step();
    chk("t4_ok", 32'(slot_ok), 32'h4);
    chk("t4_din", slot_din, 32'h12345678);
    sdram_rdy = 1'b0; slot_req = '0;
    step(); step();
    chk("t4_single_ok", 32'(ok_count - ok_before), 32'd1);

    // Download gating, then request withdrawal after grant
    downloading = 1'b1; slot_req = 4'b1000; slot_addr[3*AW +: AW] = 22'h002FF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_blocked", {31'd0, sdram_req}, 32'd0);
    end
    downloading = 1'b0;
    step();
    chk("t5_grant", {31'd0, sdram_req}, 32'd1);
    chk("t5_addr", 32'(sdram_addr), 32'h002FF);
    slot_req = '0; downloading = 1'b1;
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_data = 16'hAAAA;
    step();
    sdram_ack = 1'b0; sdram_data = 16'hBBBB;
    step();
    chk("t5_ok", 32'(slot_ok), 32'h8);
    chk("t5_din", slot_din, 32'hBBBBAAAA);
    sdram_rdy = 1'b0; downloading = 1'b0;
    step();

    // Reset in WAIT after the first beat
    ok_before = ok_count;
    slot_req = 4'b0001; slot_addr[0*AW +: AW] = 22'h00055;
    step();
    chk("t6_addr", 32'(sdram_addr), 32'h00055);
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_data = 16'h1357;
    step();
    sdram_ack = 1'b0; sdram_rdy = 1'b0; slot_req = '0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_addr", 32'(sdram_addr), 32'd0);
    chk("t6_rst_din", slot_din, 32'd0);
    step();
    rst = 1'b0; sdram_rdy = 1'b1; sdram_data = 16'h2468;
    step();
    sdram_rdy = 1'b0;
    step(); step();
    chk("t6_no_ok", 32'(ok_count - ok_before), 32'd0);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    chk("t6_din", slot_din, 32'd0);
    chk("t6_req", {31'd0, sdram_req}, 32'd0);

    // Clean read after reset: slot 0 has priority, beats restart at [15:0]
    slot_req = 4'b0011; slot_addr[1*AW +: AW] = 22'h00066;
    step();
    chk("t7_addr", 32'(sdram_addr), 32'h00055);
    sdram_ack = 1'b1; sdram_rdy = 1'b0;
    step();
    sdram_ack = 1'b0; sdram_rdy = 1'b1; sdram_data = 16'h0001;
    step();
    sdram_data = 16'h0002;
    step();
    chk("t7_ok", 32'(slot_ok), 32'h1);
    chk("t7_din", slot_din, 32'h00020001);
    sdram_rdy = 1'b0; slot_req = '0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtframe_romserve.md
# jtframe_romserve

Serving end of the ROM request protocol. Up to SLOTS ROM clients each raise `slot_req` with a word address, and this block arbitrates among them round-robin. It issues one read at a time to the SDRAM controller, assembles two 16-bit beats into a 32-bit word, and returns that word on a shared bus with a one-cycle per-slot `slot_ok` strobe. It sits between the per-client request modules and the SDRAM controller.

## Interface
- `SLOTS`, 4, number of clients (2..8).
- `AW`, 22, SDRAM word address width.
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `downloading`  in  1  ROM load in progress; blocks new grants.
- `slot_req`  in  SLOTS  per-client request, level.
- `slot_addr`  in  SLOTS*AW  client k address at bits [k*AW +: AW].
- `slot_ok`  out  SLOTS  one-cycle data-valid strobe for client k.
- `slot_din`  out  32  shared return data, {beat1, beat0}.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `sdram_req`  out  1  read request to controller, level until acked.
- `sdram_addr`  out  AW  read address, stable while `sdram_req` is high.
- `sdram_ack`  in  1  controller accepted the request.
- `sdram_rdy`  in  1  data beat valid on `sdram_data`.
- `sdram_data`  in  16  read data beat.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `downloading`=0 and any `slot_req` is high, grant the first requesting slot searching from `last+1` upward, modulo SLOTS.
  - On grant: latch slot index into `cur`, latch its address into `sdram_addr`, set `sdram_req`=1, go to REQ.
- **REQ**
  - Hold `sdram_req` and `sdram_addr` until `sdram_ack` is sampled high.
  - On ack: clear `sdram_req` at the same edge and go to WAIT.
  - If `sdram_rdy` is high in the ack cycle, it counts as beat 0.
- **WAIT**
  - Each cycle with `sdram_rdy`=1 captures `sdram_data`: first beat into [15:0], second into [31:16].
  - Beats need not be consecutive.
  - After the second beat, load the 32-bit word into `slot_din` and go to DONE.
- **DONE**
  - `slot_ok[cur]`=1 for exactly this cycle; `last`=`cur`; next state IDLE.
  - No grant is made in DONE. This gives the served client one edge to drop its request.
- `slot_din` holds its value until the next DONE.
- `sdram_rdy` seen in IDLE or DONE is ignored. `sdram_rdy` in REQ without `sdram_ack` is ignored.
- A client that drops `slot_req` after grant does not abort the transaction. The read completes and `slot_ok` still pulses.
- `downloading` rising mid-transaction does not abort the transaction; it only suppresses grants in IDLE.
- Changes to `slot_addr` after grant are ignored.

## Timing
- Reset values:
  - state IDLE; `last`=SLOTS-1, so slot 0 has first priority.
  - `cur`=0, `sdram_req`=0, `sdram_addr`=0, `slot_ok`=0, `slot_din`=0, `busy`=0, beat counter 0.
- Cycle numbering: the IDLE cycle that sees a request is t0.
  - t1: `sdram_req`=1.
  - Ack at ta ≥ t1.
  - Second beat at tb ≥ ta.
  - `slot_ok` at tb+1.
  - Minimum latency with ack at t1 and beats at t1 and t2: `slot_ok` at t3.
- Back-to-back service: DONE at td, IDLE at td+1, next `sdram_req` at td+2 at the earliest.
- `busy`=1 from t1 through DONE inclusive.
- Asynchronous reset mid-transaction forces all reset values immediately. No `slot_ok` is emitted for the aborted read. A beat arriving after reset release is ignored (IDLE).
- At most one `slot_ok` bit is high in any cycle.

## Test plan
- Single request: slot 1 requests addr 0x00123, ack immediate, beats 0xBEEF then 0xDEAD.
  - Expect `sdram_addr`=0x00123 at t1, `slot_ok`=4'b0010 at t3, `slot_din`=0xDEADBEEF.
- Simultaneous requests: slots 0 and 2 requesting from reset.
  - Expect slot 0 served first, then slot 2; the second `sdram_req` rises 2 cycles after the first `slot_ok`.
- Fairness: all 4 slots held high for 8 transactions.
  - Expect `slot_ok` order 0,1,2,3,0,1,2,3.
- Slow controller: ack delayed 5 cycles, beats separated by 3 idle cycles.
  - Expect `sdram_req` high for exactly 5 cycles with stable address.
  - Expect a single `slot_ok`, with data correct.
- Download gating and request withdrawal: `downloading`=1 with slot 3 requesting.
  - Expect no `sdram_req`; grant occurs 1 cycle after `downloading` falls.
  - If slot 3 drops `slot_req` after grant, `slot_ok[3]` still pulses.
- Reset mid-read: assert `rst` in WAIT after beat 0, release, then send a stray `sdram_rdy`.
  - Expect all outputs at reset values, no `slot_ok`, FSM in IDLE.
